nivel2_microondas: RTL and testbench

NIVEL2_MICROONDAS -- requirements
Module: nivel2_microondas

---
 rtl/nivel2_pkg.sv | 34 +++
 rtl/nivel2_microondas_bcd_7seg.sv | 29 ++
 rtl/nivel2_microondas.sv | 208 ++++++++++++++++++++
 tb/tb_nivel2_microondas.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nivel2_pkg.sv
// Shared definitions for the microwave oven controller.
// Holds the controller state encoding, the BCD digit type, the active-low
// seven-segment patterns (bit0 = a ... bit6 = g) and a BCD down-step helper.
package nivel2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One BCD digit counted down by one; 0 wraps to 'top' (the caller owns the
  // borrow into the next digit).
  function automatic bcd_t bcd_step_down(input bcd_t d, input bcd_t top);
    return (d == 4'd0) ? top : bcd_t'(d - 4'd1);
  endfunction

endpackage

// File: rtl/nivel2_microondas_bcd_7seg.sv
// bcd_7seg: combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd  - 4-bit BCD digit; codes above 9 show as a blank digit
//   segs - active-low segments, bit0 = a ... bit6 = g
module bcd_7seg
  import nivel2_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    case (bcd)
      4'd0: segs = SEG_0;
      4'd1: segs = SEG_1;
      4'd2: segs = SEG_2;
      4'd3: segs = SEG_3;
      4'd4: segs = SEG_4;
      4'd5: segs = SEG_5;
      4'd6: segs = SEG_6;
      4'd7: segs = SEG_7;
      4'd8: segs = SEG_8;
      4'd9: segs = SEG_9;
      default: segs = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/nivel2_microondas.sv
// nivel2_microondas: microwave oven controller.
// Keypad time entry as BCD digits {minutes, sec_tens, sec_ones}, countdown
// while cooking, pause/resume, cook-complete flag and a per-second power
// duty window driving the magnetron.
// Ports:
//   clock, reset         - sole clock, synchronous active-high reset
//   key[9:0]             - one-hot keypad, bit n = digit n
//   startn/stopn/clearn  - active-low level buttons
//   door_closed          - 1 = door closed
//   power                - latched power level, POWER_LEVELS-1 = full power
//   sec_ones_segs, sec_tens_segs, min_segs - active-low digit displays
//   blank_digit          - constant blank pattern
//   mag_on, done         - registered magnetron enable / cook-complete flag
//   state_dbg            - current controller state (state_t encoding)
module nivel2_microondas
  import nivel2_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MIN_DIGITS    = 1,
  parameter int POWER_LEVELS  = 10
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [9:0]                    key,
  input  logic                          startn,
  input  logic                          stopn,
  input  logic                          clearn,
  input  logic                          door_closed,
  input  logic [$clog2(POWER_LEVELS)-1:0] power,
  output logic [6:0]                    sec_ones_segs,
  output logic [6:0]                    sec_tens_segs,
  output logic [7*MIN_DIGITS-1:0]       min_segs,
  output logic [6:0]                    blank_digit,
  output logic                          mag_on,
  output logic                          done,
  output logic [2:0]                    state_dbg
);

  localparam int NDIG = MIN_DIGITS + 2;
  localparam int PW   = $clog2(POWER_LEVELS);
  localparam int TW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] WIN_LAST  = PW'(POWER_LEVELS - 1);

  // Digit index 0 = sec_ones, 1 = sec_tens, 2.. = minutes (LSD first).
  state_t        state_q, state_n;
  bcd_t          dig_q     [NDIG];
  bcd_t          dig_n     [NDIG];
  bcd_t          dig_shift [NDIG];
  bcd_t          dig_dec   [NDIG];
  logic [TW-1:0] tick_q, tick_n;
  logic [PW-1:0] win_q, win_n;
  logic [PW-1:0] pwr_q, pwr_n;
  logic [9:0]    key_q;
  logic          mag_q, mag_n;
  logic          done_q, done_n;

  logic          key_ok;
  bcd_t          key_val;
  logic          time_zero;
  logic          dec_zero;
  logic          borrow;
  logic          can_start;

  // A key is taken only on the cycle it turns exactly one-hot after a cycle
  // of all-zero, so a held key enters once and multi-hot chords are dropped.
  always_comb begin
    key_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) key_val = 4'(i);
    end
    key_ok = (key != 10'd0) && ((key & (key - 10'd1)) == 10'd0) && (key_q == 10'd0);
  end

  // Shifted-entry and one-second-decrement candidates for the digit register.
  // sec_tens borrows to 5, every other digit to 9; tens values 6..9 entered
  // from the keypad simply count down.
  always_comb begin
    dig_shift[0] = key_val;
    for (int i = 1; i < NDIG; i++) dig_shift[i] = dig_q[i-1];

    borrow    = 1'b1;
    time_zero = 1'b1;
    dec_zero  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        dig_dec[i] = bcd_step_down(dig_q[i], (i == 1) ? 4'd5 : 4'd9);
        borrow     = (dig_q[i] == 4'd0);
      end else begin
        dig_dec[i] = dig_q[i];
      end
      if (dig_q[i] != 4'd0)   time_zero = 1'b0;
      if (dig_dec[i] != 4'd0) dec_zero  = 1'b0;
    end
  end

  // Next-state logic. Priority: clear > door open > stop > start > key.
  // An open door only acts while cooking (pause) or done (back to idle);
  // elsewhere it just blocks start, so time can be keyed in with the door open.
  always_comb begin
    state_n = state_q;
    for (int i = 0; i < NDIG; i++) dig_n[i] = dig_q[i];
    tick_n    = tick_q;
    win_n     = win_q;
    pwr_n     = pwr_q;
    done_n    = done_q;
    can_start = door_closed && !time_zero;

    if (!clearn) begin
      state_n = ST_IDLE;
      for (int i = 0; i < NDIG; i++) dig_n[i] = 4'd0;
      tick_n  = '0;
      win_n   = '0;
      done_n  = 1'b0;
    end else begin
      case (state_q)
        ST_COOK: begin
          if (!door_closed || !stopn) begin
            state_n = ST_PAUSE;
          end else if (tick_q == TICK_LAST) begin
            tick_n = '0;
            win_n  = (win_q == WIN_LAST) ? '0 : win_q + 1'b1;
            for (int i = 0; i < NDIG; i++) dig_n[i] = dig_dec[i];
            if (dec_zero) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end
          end else begin
            tick_n = tick_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (!door_closed) begin
            state_n = ST_IDLE;
            done_n  = 1'b0;
          end else if (stopn && key_ok) begin
            for (int i = 0; i < NDIG; i++) dig_n[i] = dig_shift[i];
            state_n = ST_ENTRY;
            done_n  = 1'b0;
          end
        end
        ST_IDLE, ST_ENTRY, ST_PAUSE: begin
          if (stopn) begin
            if (!startn && (state_q != ST_IDLE) && can_start) begin
              state_n = ST_COOK;
              pwr_n   = power;
              // Resuming from pause keeps the partial second and duty window.
              if (state_q == ST_ENTRY) begin
                tick_n = '0;
                win_n  = '0;
              end
            end else if (key_ok) begin
              for (int i = 0; i < NDIG; i++) dig_n[i] = dig_shift[i];
              if (state_q != ST_PAUSE) state_n = ST_ENTRY;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    // Registered from next-state values so mag_on tracks the state it enters.
    mag_n = (state_n == ST_COOK) && (win_n <= pwr_n);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= 4'd0;
      tick_q  <= '0;
      win_q   <= '0;
      pwr_q   <= '0;
      key_q   <= 10'd0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      for (int i = 0; i < NDIG; i++) dig_q[i] <= dig_n[i];
      tick_q  <= tick_n;
      win_q   <= win_n;
      pwr_q   <= pwr_n;
      key_q   <= key;
      mag_q   <= mag_n;
      done_q  <= done_n;
    end
  end

  logic [6:0] seg_w [NDIG];

  for (genvar g = 0; g < NDIG; g++) begin : g_seg
    bcd_7seg u_seg (
      .bcd  (dig_q[g]),
      .segs (seg_w[g])
    );
  end

  for (genvar m = 0; m < MIN_DIGITS; m++) begin : g_min
    assign min_segs[7*m +: 7] = seg_w[m+2];
  end

  assign sec_ones_segs = seg_w[0];
  assign sec_tens_segs = seg_w[1];
  assign blank_digit   = SEG_BLANK;
  assign mag_on        = mag_q;
  assign done          = done_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_nivel2_microondas.sv
// Directed bench for nivel2_microondas with TICKS_PER_SEC=4, MIN_DIGITS=1,
// POWER_LEVELS=4. Inputs change 1 ns after a rising edge; outputs are read
// at the same point, after the registers have settled.
module tb_nivel2_microondas;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_COOK  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] key = 10'd0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b1;
  logic [1:0] power = 2'd3;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_segs, blank_digit;
  logic       mag_on, done;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  nivel2_microondas #(
    .TICKS_PER_SEC (4),
    .MIN_DIGITS    (1),
    .POWER_LEVELS  (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .key           (key),
    .startn        (startn),
    .stopn         (stopn),
    .clearn        (clearn),
    .door_closed   (door_closed),
    .power         (power),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .min_segs      (min_segs),
    .blank_digit   (blank_digit),
    .mag_on        (mag_on),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int m, input int t, input int o);
    chk(tag, {11'd0, min_segs, sec_tens_segs, sec_ones_segs}, {11'd0, seg(m), seg(t), seg(o)});
  endtask

  task automatic press(input int d);
    key = 10'b1 << d;
    cyc(1);
    key = 10'd0;
    cyc(1);
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
  endtask

  task automatic pulse_clear();
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
  endtask

  logic exp_duty [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state
    cyc(2);
    chk_disp("reset_disp", 0, 0, 0);
    chk("reset_state", state_dbg, S_IDLE);
    chk("reset_mag", mag_on, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("blank", blank_digit, 7'b1111111);
    reset = 1'b0;
    cyc(1);

    // Keys 1,3,0 then full-power cook of 1:30 to completion
    press(1);
    chk("entry_state", state_dbg, S_ENTRY);
    chk_disp("entry_one", 0, 0, 1);
    press(3);
    press(0);
    chk_disp("entry_130", 1, 3, 0);
    power = 2'd3;
    pulse_start();
    chk("cook_state", state_dbg, S_COOK);
    chk("cook_mag_full", mag_on, 1'b1);
    cyc(3);
    chk_disp("cook_hold_130", 1, 3, 0);
    cyc(1);
    chk_disp("cook_129", 1, 2, 9);
    cyc(355);
    chk_disp("cook_001", 0, 0, 1);
    chk("cook_not_done", state_dbg, S_COOK);
    cyc(1);
    chk("done_state", state_dbg, S_DONE);
    chk("done_flag", done, 1'b1);
    chk("done_mag", mag_on, 1'b0);
    chk_disp("done_disp", 0, 0, 0);
    pulse_clear();
    chk("clear_done", done, 1'b0);
    chk("clear_state", state_dbg, S_IDLE);

    // Door open: key still enters, start is ignored
    door_closed = 1'b0;
    press(5);
    chk_disp("door_key", 0, 0, 5);
    pulse_start();
    chk("door_start_state", state_dbg, S_ENTRY);
    chk("door_start_mag", mag_on, 1'b0);
    door_closed = 1'b1;
    pulse_start();
    chk("door_closed_start", state_dbg, S_COOK);
    pulse_clear();

    // Power 1 of 4: on for window seconds 0-1, off for 2-3
    press(1);
    press(0);
    power = 2'd1;
    pulse_start();
    for (int s = 0; s < 6; s++) begin
      chk($sformatf("duty_s%0d", s), mag_on, exp_duty[s]);
      cyc(4);
    end
    chk_disp("duty_004", 0, 0, 4);
    pulse_clear();
    chk("clear_mag", mag_on, 1'b0);

    // Door opens at 0:07 with two ticks into the second, then resume
    press(1);
    press(0);
    power = 2'd3;
    pulse_start();
    cyc(14);
    chk_disp("pre_pause_007", 0, 0, 7);
    chk("pre_pause_mag", mag_on, 1'b1);
    door_closed = 1'b0;
    cyc(1);
    chk("pause_state", state_dbg, S_PAUSE);
    chk("pause_mag", mag_on, 1'b0);
    cyc(5);
    chk_disp("pause_frozen", 0, 0, 7);
    door_closed = 1'b1;
    pulse_start();
    chk("resume_state", state_dbg, S_COOK);
    cyc(1);
    chk_disp("resume_007", 0, 0, 7);
    cyc(1);
    chk_disp("resume_006", 0, 0, 6);
    stopn = 1'b0;
    cyc(1);
    stopn = 1'b1;
    chk("stop_pause", state_dbg, S_PAUSE);
    pulse_start();

    // Clear wins over start during cook; reset mid-cook
    clearn = 1'b0;
    startn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    startn = 1'b1;
    chk("clr_start_state", state_dbg, S_IDLE);
    chk_disp("clr_start_disp", 0, 0, 0);
    press(2);
    pulse_start();
    cyc(3);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_state", state_dbg, S_IDLE);
    chk_disp("rst_mid_disp", 0, 0, 0);
    chk("rst_mid_mag", mag_on, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    reset = 1'b0;
    cyc(1);

    // 0:99 counts down through the tens borrow
    press(9);
    press(9);
    chk_disp("entry_099", 0, 9, 9);
    pulse_start();
    cyc(4);
    chk_disp("cd_098", 0, 9, 8);
    cyc(32);
    chk_disp("cd_090", 0, 9, 0);
    cyc(4);
    chk_disp("cd_089", 0, 8, 9);
    pulse_clear();

    // Multi-hot ignored, held key enters once, MSB discarded on overflow
    press(4);
    key = 10'b0000000011;
    cyc(1);
    key = 10'd0;
    cyc(1);
    chk_disp("multi_hot", 0, 0, 4);
    key = 10'b1 << 6;
    cyc(3);
    key = 10'd0;
    cyc(1);
    chk_disp("held_key", 0, 4, 6);
    press(7);
    chk_disp("third_digit", 4, 6, 7);
    press(8);
    chk_disp("msb_drop", 6, 7, 8);
    pulse_clear();

    // Start with zero time is ignored
    press(0);
    pulse_start();
    chk("zero_start", state_dbg, S_ENTRY);
    pulse_clear();

    // Key in DONE leaves done and starts a new entry
    press(1);
    pulse_start();
    cyc(4);
    chk("short_done", done, 1'b1);
    press(3);
    chk("done_key_state", state_dbg, S_ENTRY);
    chk("done_key_flag", done, 1'b0);
    chk_disp("done_key_disp", 0, 0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
